// File: rtl/key_arbiter.sv
// key_arbiter: round-robin arbiter sharing one keymem port among NUM_CH requesters with timeout.
module key_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ID_WIDTH  = 32,
  parameter int KEY_WIDTH = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk156,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_key_req,
  input  logic [NUM_CH*ID_WIDTH-1:0] ch_key_id,
  output logic [NUM_CH-1:0]          ch_key_ack,
  output logic [NUM_CH-1:0]          ch_key_err,
  output logic [KEY_WIDTH-1:0]       ch_key,
  output logic                       km_key_req,
  output logic [ID_WIDTH-1:0]        km_key_id,
  input  logic                       km_key_ack,
  input  logic [KEY_WIDTH-1:0]       km_key,
  output logic                       busy,
  output logic [31:0]                timeout_count
);
  localparam int GW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [GW-1:0] last_grant, grant, pick, idx;
  logic [ID_WIDTH-1:0] id_q;
  logic [TW-1:0] timer;
  logic err_q, found, expire;
  always_comb begin
    pick = last_grant;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_CH);
      if (!found && ch_key_req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  // ack in the last timer cycle wins over the timeout
  assign expire = state == BUSY && !km_key_ack && timer == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (found ? BUSY : IDLE) :
              (state == BUSY) ? (km_key_ack ? DONE : expire ? IDLE : BUSY) : IDLE;
  end
  always_ff @(posedge clk156) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk156) begin
    if (reset) begin
      last_grant    <= GW'(NUM_CH - 1);
      grant         <= '0;
      id_q          <= '0;
      timer         <= '0;
      err_q         <= 1'b0;
      timeout_count <= '0;
      ch_key        <= '0;
    end else begin
      err_q <= expire;
      timer <= (state == BUSY) ? timer + 1'b1 : '0;
      if (state == IDLE && found) begin
        grant <= pick;
        id_q  <= ch_key_id[pick*ID_WIDTH +: ID_WIDTH];
      end
      if (state == BUSY && km_key_ack) ch_key <= km_key;
      if (state == BUSY && (km_key_ack || expire)) last_grant <= grant;
      if (expire && ~&timeout_count) timeout_count <= timeout_count + 1'b1;
    end
  end
  assign ch_key_ack = (state == DONE) ? NUM_CH'(1) << grant : '0;
  assign ch_key_err = err_q ? NUM_CH'(1) << grant : '0;
  assign km_key_req = state == BUSY;
  assign km_key_id  = id_q;
  assign busy       = state != IDLE;
endmodule
